// File: rtl/pc_gen_pkg.sv
// pc_pkg: shared types and constants for the program-counter generator.
// Revision 1.0
`default_nettype none

package pc_pkg;

   typedef enum logic [2:0] {
      SRC_TRAP = 3'd0,
      SRC_MRET = 3'd1,
      SRC_BR   = 3'd2,
      SRC_RET  = 3'd3,
      SRC_SEQ  = 3'd4,
      SRC_HOLD = 3'd5
   } src_e;

   typedef enum logic [0:0] {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam int INC_C = 2;
   localparam int INC_W = 4;

endpackage

`default_nettype wire

// File: rtl/pc_gen_if.sv
// pc_gen_if: control, redirect and fetch-side signals of the PC generator.
// Revision 1.0
`default_nettype none

interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            fetch_ready_i;
   logic            is_compressed_i;
   logic            branch_taken_i;
   logic [XLEN-1:0] branch_target_i;
   logic            call_i;
   logic            ret_i;
   logic            trap_i;
   logic [XLEN-1:0] trap_vector_i;
   logic            mret_i;
   logic [XLEN-1:0] epc_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pc_plus_o;
   logic            fetch_valid_o;
   logic            misalign_o;
   logic [XLEN-1:0] misalign_addr_o;
   logic            ras_empty_o;

   modport master (
      output stall_i, fetch_ready_i, is_compressed_i, branch_taken_i, branch_target_i,
             call_i, ret_i, trap_i, trap_vector_i, mret_i, epc_i,
      input  pc_o, pc_plus_o, fetch_valid_o, misalign_o, misalign_addr_o, ras_empty_o
   );

   modport slave (
      input  stall_i, fetch_ready_i, is_compressed_i, branch_taken_i, branch_target_i,
             call_i, ret_i, trap_i, trap_vector_i, mret_i, epc_i,
      output pc_o, pc_plus_o, fetch_valid_o, misalign_o, misalign_addr_o, ras_empty_o
   );
endinterface

`default_nettype wire

// File: rtl/pc_gen_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
// Revision 1.0
`default_nettype none

module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     reset_ni,
   input  wire logic                     i_push,
   input  wire logic                     i_pop,
   input  wire logic [XLEN-1:0]          i_data,
   output logic      [XLEN-1:0]          o_top,
   output logic                          o_empty,
   output logic      [$clog2(DEPTH):0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_top;
   logic [CW-1:0]   r_count;
   logic            w_pop;
   logic [PW-1:0]   w_top_inc;

   assign w_pop     = i_pop && (r_count != '0);
   assign w_top_inc = r_top + PW'(1);

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (i_push && !w_pop) begin
         r_top <= w_top_inc;
         if (r_count != CW'(DEPTH)) begin
            r_count <= r_count + CW'(1);
         end
      end else if (w_pop && !i_push) begin
         r_top   <= r_top - PW'(1);
         r_count <= r_count - CW'(1);
      end
   end

   // Storage carries no reset: entries are only read while the count is non-zero.
   always_ff @(posedge clk) begin
      if (reset_ni) begin
         if (i_push && w_pop) begin
            r_mem[r_top] <= i_data;
         end else if (i_push) begin
            r_mem[w_top_inc] <= i_data;
         end
      end
   end

   assign o_top   = r_mem[r_top];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with prioritised next-PC selection, misalignment check and RAS.
// Revision 1.0
`default_nettype none

module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
   parameter int              SUPPORT_C    = 0,
   parameter int              RAS_DEPTH    = 4
) (
   input wire logic clk,
   input wire logic reset_ni,
   pc_gen_if.slave  bus
);
   localparam logic [XLEN-1:0] ALIGN_MASK = (SUPPORT_C != 0) ? XLEN'(1) : XLEN'(3);

   state_e            r_state;
   state_e            w_state_nxt;
   src_e              w_src;
   logic [XLEN-1:0]   r_pc;
   logic              r_misalign;
   logic [XLEN-1:0]   r_misalign_addr;
   logic [XLEN-1:0]   w_inc;
   logic [XLEN-1:0]   w_pc_plus;
   logic [XLEN-1:0]   w_next_pc;
   logic [XLEN-1:0]   w_tgt;
   logic [XLEN-1:0]   w_ret_tgt;
   logic              w_bad;
   logic              w_push;
   logic              w_pop;
   logic [XLEN-1:0]   w_ras_top;
   logic              w_ras_empty;
   logic [$clog2(RAS_DEPTH):0] w_ras_count;

   assign w_inc     = ((SUPPORT_C != 0) && bus.is_compressed_i) ? XLEN'(INC_C) : XLEN'(INC_W);
   assign w_pc_plus = reset_ni ? (r_pc + w_inc) : (RESET_VECTOR + XLEN'(INC_W));
   assign w_ret_tgt = (w_ras_count != '0) ? w_ras_top : bus.branch_target_i;

   always_comb begin
      w_state_nxt = S_RUN;
      w_src       = SRC_HOLD;
      w_tgt       = bus.branch_target_i;
      w_next_pc   = r_pc;
      w_bad       = 1'b0;
      if (r_state == S_RUN) begin
         if (bus.trap_i)                                w_src = SRC_TRAP;
         else if (bus.mret_i)                           w_src = SRC_MRET;
         else if (bus.branch_taken_i)                   w_src = SRC_BR;
         else if (bus.ret_i)                            w_src = SRC_RET;
         else if (bus.fetch_ready_i && !bus.stall_i)    w_src = SRC_SEQ;
      end
      if (w_src == SRC_RET) begin
         w_tgt = w_ret_tgt;
      end
      if ((w_src == SRC_BR) || (w_src == SRC_RET)) begin
         w_bad = |(w_tgt & ALIGN_MASK);
      end
      case (w_src)
         SRC_TRAP: w_next_pc = bus.trap_vector_i & ~ALIGN_MASK;
         SRC_MRET: w_next_pc = bus.epc_i & ~ALIGN_MASK;
         SRC_BR,
         SRC_RET:  w_next_pc = w_bad ? r_pc : w_tgt;
         SRC_SEQ:  w_next_pc = w_pc_plus;
         default:  w_next_pc = r_pc;
      endcase
   end

   assign w_push = (w_src == SRC_BR) && bus.call_i && !w_bad;
   assign w_pop  = (w_src == SRC_RET) && (w_ras_count != '0);

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         r_state         <= S_BOOT;
         r_pc            <= RESET_VECTOR;
         r_misalign      <= 1'b0;
         r_misalign_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_next_pc;
         r_misalign <= w_bad;
         if (w_bad) begin
            r_misalign_addr <= w_tgt;
         end
      end
   end

   pc_ras #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .reset_ni (reset_ni),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_data   (w_pc_plus),
      .o_top    (w_ras_top),
      .o_empty  (w_ras_empty),
      .o_count  (w_ras_count)
   );

   assign bus.pc_o            = r_pc;
   assign bus.pc_plus_o       = w_pc_plus;
   assign bus.fetch_valid_o   = (r_state == S_RUN);
   assign bus.misalign_o      = r_misalign;
   assign bus.misalign_addr_o = r_misalign_addr;
   assign bus.ras_empty_o     = w_ras_empty;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table on a 4-byte PC generator plus corner sequences on a compressed one.
// Revision 1.0
`default_nettype none

module tb_pc_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pc_gen_if #(.XLEN(32)) if0 ();
   pc_gen_if #(.XLEN(32)) if1 ();

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .SUPPORT_C(0), .RAS_DEPTH(4)) u_dut0 (
      .clk(clk), .reset_ni(rst_n), .bus(if0));
   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .SUPPORT_C(1), .RAS_DEPTH(4)) u_dut1 (
      .clk(clk), .reset_ni(rst_n), .bus(if1));

   typedef struct packed {
      logic        rst_n, stall, ready, comp, br, call, ret, trap, mret;
      logic [31:0] tgt, tvec, epc, exp_pc;
      logic        exp_valid, exp_mis, exp_empty;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n = v.rst_n;
      if0.stall_i = v.stall;  if1.stall_i = v.stall;
      if0.fetch_ready_i = v.ready;  if1.fetch_ready_i = v.ready;
      if0.is_compressed_i = v.comp; if1.is_compressed_i = v.comp;
      if0.branch_taken_i = v.br;    if1.branch_taken_i = v.br;
      if0.branch_target_i = v.tgt;  if1.branch_target_i = v.tgt;
      if0.call_i = v.call;  if1.call_i = v.call;
      if0.ret_i = v.ret;    if1.ret_i = v.ret;
      if0.trap_i = v.trap;  if1.trap_i = v.trap;
      if0.trap_vector_i = v.tvec; if1.trap_vector_i = v.tvec;
      if0.mret_i = v.mret;  if1.mret_i = v.mret;
      if0.epc_i = v.epc;    if1.epc_i = v.epc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t idle(input logic rn, input logic rdy);
      vec_t v;
      v = '0;
      v.rst_n = rn;
      v.ready = rdy;
      return v;
   endfunction

   initial begin
      vec_t v;
      //       rst stl rdy cmp br cal ret trp mrt tgt            tvec           epc            exp_pc         val mis emp
      vecs.push_back('{0,0,0,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0000, 0,0,1});
      vecs.push_back('{0,0,0,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0000, 0,0,1});
      vecs.push_back('{0,0,0,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0000, 0,0,1});
      vecs.push_back('{1,0,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0000, 1,0,1});
      vecs.push_back('{1,0,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 1,0,1});
      vecs.push_back('{1,1,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 1,0,1});
      vecs.push_back('{1,1,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 1,0,1});
      vecs.push_back('{1,0,0,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0004, 1,0,1});
      vecs.push_back('{1,0,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0008, 1,0,1});
      vecs.push_back('{1,0,1,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_000C, 1,0,1});
      vecs.push_back('{1,0,1,0, 1,1,0,0,0, 32'h2000,      32'h0,         32'h0,         32'h0000_2000, 1,0,0});
      vecs.push_back('{1,0,1,0, 1,1,0,1,1, 32'h400,       32'h100,       32'h300,       32'h0000_0100, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,0,0,1, 32'h0,         32'h0,         32'h302,       32'h0000_0300, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0010, 1,0,1});
      vecs.push_back('{1,0,0,0, 1,0,0,0,0, 32'h1002,      32'h0,         32'h0,         32'h8000_0010, 1,1,1});
      vecs.push_back('{1,0,0,0, 0,0,0,0,0, 32'h0,         32'h0,         32'h0,         32'h8000_0010, 1,0,1});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h4000,      32'h0,         32'h0,         32'h0000_4000, 1,0,1});
      vecs.push_back('{1,1,0,0, 0,0,0,1,0, 32'h0,         32'h203,       32'h0,         32'h0000_0200, 1,0,1});
      vecs.push_back('{1,0,0,0, 1,0,0,0,0, 32'h1000,      32'h0,         32'h0,         32'h0000_1000, 1,0,1});
      vecs.push_back('{1,0,0,0, 1,1,0,0,0, 32'h2000,      32'h0,         32'h0,         32'h0000_2000, 1,0,0});
      vecs.push_back('{1,0,0,0, 1,1,0,0,0, 32'h3000,      32'h0,         32'h0,         32'h0000_3000, 1,0,0});
      vecs.push_back('{1,0,0,0, 1,1,0,0,0, 32'h4000,      32'h0,         32'h0,         32'h0000_4000, 1,0,0});
      vecs.push_back('{1,0,0,0, 1,1,0,0,0, 32'h5000,      32'h0,         32'h0,         32'h0000_5000, 1,0,0});
      vecs.push_back('{1,0,0,0, 1,1,0,0,0, 32'h6000,      32'h0,         32'h0,         32'h0000_6000, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h9000_0000, 32'h0,         32'h0,         32'h0000_5004, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h9000_0000, 32'h0,         32'h0,         32'h0000_4004, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h9000_0000, 32'h0,         32'h0,         32'h0000_3004, 1,0,0});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h9000_0000, 32'h0,         32'h0,         32'h0000_2004, 1,0,1});
      vecs.push_back('{1,0,0,0, 0,0,1,0,0, 32'h9000_0000, 32'h0,         32'h0,         32'h9000_0000, 1,0,1});

      foreach (vecs[i]) begin
         drive(vecs[i]);
         step();
         chk($sformatf("v%0d pc", i),    if0.pc_o, vecs[i].exp_pc);
         chk($sformatf("v%0d plus", i),  if0.pc_plus_o, vecs[i].exp_pc + 32'd4);
         chk($sformatf("v%0d valid", i), {31'd0, if0.fetch_valid_o}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("v%0d mis", i),   {31'd0, if0.misalign_o}, {31'd0, vecs[i].exp_mis});
         chk($sformatf("v%0d empty", i), {31'd0, if0.ras_empty_o}, {31'd0, vecs[i].exp_empty});
      end
      chk("c0 mis addr", if0.misalign_addr_o, 32'h0000_1002);

      // Compressed increment and address wrap on the SUPPORT_C=1 instance.
      v = idle(1, 0); v.br = 1; v.tgt = 32'hFFFF_FFFE;
      drive(v); step();
      chk("c1 pc top", if1.pc_o, 32'hFFFF_FFFE);
      chk("c0 4B mis", {31'd0, if0.misalign_o}, 32'd1);
      chk("c0 4B addr", if0.misalign_addr_o, 32'hFFFF_FFFE);
      chk("c0 4B pc held", if0.pc_o, 32'h9000_0000);
      v = idle(1, 0); v.comp = 1;
      drive(v); #1;
      chk("c1 plus wrap2", if1.pc_plus_o, 32'h0000_0000);
      v.comp = 0;
      drive(v); #1;
      chk("c1 plus wrap4", if1.pc_plus_o, 32'h0000_0002);
      v = idle(1, 1); v.comp = 1;
      drive(v); step();
      chk("c1 pc wrap", if1.pc_o, 32'h0000_0000);
      chk("c0 mis clear", {31'd0, if0.misalign_o}, 32'd0);
      step();
      chk("c1 pc step2", if1.pc_o, 32'h0000_0002);
      chk("c0 comp ignored", if0.pc_o, 32'h9000_0008);
      v = idle(1, 0); v.br = 1; v.tgt = 32'h8000_0003;
      drive(v); step();
      chk("c1 mis pulse", {31'd0, if1.misalign_o}, 32'd1);
      chk("c1 mis addr", if1.misalign_addr_o, 32'h8000_0003);
      chk("c1 mis pc held", if1.pc_o, 32'h0000_0002);
      drive(idle(1, 0)); step();
      chk("c1 mis one cycle", {31'd0, if1.misalign_o}, 32'd0);
      chk("c1 mis addr kept", if1.misalign_addr_o, 32'h8000_0003);

      // Reset asserted during a call redirect.
      v = idle(1, 0); v.br = 1; v.call = 1; v.tgt = 32'h3000;
      drive(v); step();
      chk("r call nonempty", {31'd0, if0.ras_empty_o}, 32'd0);
      v = idle(0, 1); v.br = 1; v.call = 1; v.comp = 1; v.tgt = 32'h7000;
      drive(v); #1;
      chk("r plus in reset", if1.pc_plus_o, 32'h8000_0004);
      step();
      chk("r pc", if0.pc_o, 32'h8000_0000);
      chk("r valid", {31'd0, if0.fetch_valid_o}, 32'd0);
      chk("r empty", {31'd0, if0.ras_empty_o}, 32'd1);
      chk("r mis addr", if0.misalign_addr_o, 32'h0);
      v = idle(1, 1); v.br = 1; v.tgt = 32'h7000;
      drive(v); #1;
      chk("r boot valid", {31'd0, if0.fetch_valid_o}, 32'd0);
      step();
      chk("r boot pc held", if0.pc_o, 32'h8000_0000);
      chk("r run valid", {31'd0, if0.fetch_valid_o}, 32'd1);
      drive(idle(1, 1)); step();
      chk("r pc step", if0.pc_o, 32'h8000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
